tt_um_carry_select: RTL and testbench

- 4-bit carry-select adder with registered output, wrapped in the standard 8-in/8-out user-project pin interface.
- Operands A and B arrive packed on ui_in. Sum and carry flags appear on uo_out one clock later.
- Datapath is split into two 2-bit groups:
  - Low group: plain ripple adder with carry-in 0.
  - High group: computed twice in parallel, for carry-in 0 and carry-in 1. The low-group carry selects between the two results.

---
 rtl/tt_um_carry_select_if.sv | 8 +
 rtl/tt_um_carry_select.sv | 124 ++++++++++++
 tb/tb_tt_um_carry_select.sv | 113 +++++++++++
 3 files changed

// File: rtl/tt_um_carry_select_if.sv
// Pin bundle of the 8-in/8-out user project: packed operands in, flags and sum out.
interface tt_um_carry_select_if;
    logic [7:0] ui_in;
    logic [7:0] uo_out;

    modport master (output ui_in, input uo_out);
    modport slave  (input ui_in, output uo_out);
endinterface

// File: rtl/tt_um_carry_select.sv
// 4-bit carry-select adder, two 2-bit groups, one-cycle registered result.
// uo_out = {2'b00, low-group carry, final carry, sum}.
module tt_um_carry_select (
    input  logic                    clk,
    input  logic                    rst,
    tt_um_carry_select_if.slave     bus
);
    localparam int unsigned WIDTH = 4;
    localparam int unsigned GROUP = 2;
    localparam int unsigned OUT_W = 8;

    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [GROUP-1:0] s_lo;
    logic [GROUP-1:0] s_hi0;
    logic [GROUP-1:0] s_hi1;
    logic [GROUP-1:0] s_hi;
    logic             c0;
    logic             k0;
    logic             k1;
    logic             c1;
    logic [OUT_W-1:0] result_q;

    assign a = bus.ui_in[WIDTH-1:0];
    assign b = bus.ui_in[OUT_W-1:WIDTH];

    tt_um_carry_select_rca2 u_lo (
        .a     (a[GROUP-1:0]),
        .b     (b[GROUP-1:0]),
        .cin   (1'b0),
        .s_c   (s_lo),
        .co_c  (c0)
    );

    // High group is evaluated for both carry-ins so only the mux waits on c0
    tt_um_carry_select_rca2 u_hi0 (
        .a     (a[WIDTH-1:GROUP]),
        .b     (b[WIDTH-1:GROUP]),
        .cin   (1'b0),
        .s_c   (s_hi0),
        .co_c  (k0)
    );

    tt_um_carry_select_rca2 u_hi1 (
        .a     (a[WIDTH-1:GROUP]),
        .b     (b[WIDTH-1:GROUP]),
        .cin   (1'b1),
        .s_c   (s_hi1),
        .co_c  (k1)
    );

    tt_um_carry_select_mux2 u_sel (
        .sel   (c0),
        .s0    (s_hi0),
        .k0    (k0),
        .s1    (s_hi1),
        .k1    (k1),
        .s_c   (s_hi),
        .k_c   (c1)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            result_q <= '0;
        end else begin
            result_q <= {2'b00, c0, c1, s_hi, s_lo};
        end
    end

    assign bus.uo_out = result_q;
endmodule

// Single-bit full adder cell.
module tt_um_carry_select_fa (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s_c,
    output logic co_c
);
    assign s_c  = a ^ b ^ cin;
    assign co_c = (a & b) | (cin & (a ^ b));
endmodule

// 2-bit ripple adder built from two full-adder cells.
module tt_um_carry_select_rca2 (
    input  logic [1:0] a,
    input  logic [1:0] b,
    input  logic       cin,
    output logic [1:0] s_c,
    output logic       co_c
);
    logic c_mid;

    tt_um_carry_select_fa u_fa0 (
        .a    (a[0]),
        .b    (b[0]),
        .cin  (cin),
        .s_c  (s_c[0]),
        .co_c (c_mid)
    );

    tt_um_carry_select_fa u_fa1 (
        .a    (a[1]),
        .b    (b[1]),
        .cin  (c_mid),
        .s_c  (s_c[1]),
        .co_c (co_c)
    );
endmodule

// 2:1 select of a 2-bit group sum together with its carry.
module tt_um_carry_select_mux2 (
    input  logic       sel,
    input  logic [1:0] s0,
    input  logic       k0,
    input  logic [1:0] s1,
    input  logic       k1,
    output logic [1:0] s_c,
    output logic       k_c
);
    assign s_c = sel ? s1 : s0;
    assign k_c = sel ? k1 : k0;
endmodule

// File: tb/tb_tt_um_carry_select.sv
// Scoreboard bench: driver pushes expected results, monitor pops one per clock edge.
module tb_tt_um_carry_select;
    logic clk;
    logic rst;
    int   tests;
    int   fails;
    bit   done;
    logic [7:0] expq[$];

    tt_um_carry_select_if bus ();

    tt_um_carry_select dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: arithmetic on the operand values, not on the adder structure
    function automatic logic [7:0] model(input logic r, input logic [7:0] ui);
        int a;
        int b;
        int lo_carry;
        logic [7:0] v;
        a = int'(ui[3:0]);
        b = int'(ui[7:4]);
        lo_carry = ((a % 4) + (b % 4)) / 4;
        v = 8'(a + b + 32 * lo_carry);
        if (r) v = 8'h00;
        return v;
    endfunction

    task automatic apply(input logic r, input logic [7:0] ui);
        rst = r;
        bus.ui_in = ui;
        expq.push_back(model(r, ui));
        @(negedge clk);
    endtask

    // Monitor: every rising edge produces exactly one registered result
    initial begin
        logic [7:0] want;
        forever begin
            @(posedge clk);
            #1;
            if (!done) begin
                tests++;
                if (expq.size() == 0) begin
                    fails++;
                    $display("FAIL uo_out_unexpected got=%02h required=none", bus.uo_out);
                end else begin
                    want = expq.pop_front();
                    if (bus.uo_out !== want) begin
                        fails++;
                        $display("FAIL uo_out t=%0t ui_in_prev got=%02h required=%02h",
                                 $time, bus.uo_out, want);
                    end
                end
            end
        end
    end

    initial begin
        logic [7:0] ui;
        int k;
        done  = 1'b0;
        tests = 0;
        fails = 0;

        // Reset held for two edges with all-ones operands, then release
        apply(1'b1, 8'hFF);
        apply(1'b1, 8'hFF);
        apply(1'b0, 8'hFF);
        // Directed cases: select path, full wrap, max, back-to-back stream
        apply(1'b0, 8'h35);
        apply(1'b0, 8'h1F);
        apply(1'b0, 8'hFF);
        apply(1'b0, 8'h12);
        apply(1'b0, 8'h84);
        apply(1'b0, 8'h00);
        // Mid-stream reset discards the pending sum
        apply(1'b0, 8'hEE);
        apply(1'b1, 8'h77);
        apply(1'b0, 8'h99);

        for (int i = 0; i < 256; i++) begin
            ui = 8'(i);
            apply(1'b0, ui);
        end

        for (int i = 0; i < 300; i++) begin
            ui = 8'($urandom_range(0, 255));
            apply(($urandom_range(0, 19) == 0) ? 1'b1 : 1'b0, ui);
        end

        // Bounded drain of the scoreboard
        k = 0;
        while (expq.size() != 0 && k < 10) begin
            @(negedge clk);
            k++;
        end
        done = 1'b1;
        if (expq.size() != 0) begin
            fails++;
            $display("FAIL drain remaining=%0d required=0", expq.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
